// File: rtl/sar_adc.sv
// Behavioural successive-approximation ADC: samples a real input, resolves one
// bit per clock MSB first against an internal trial DAC, then strobes the code.
`timescale 1ns/1ps

module sar_adc #(
  parameter real Vref  = 3.3,
  parameter int  NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  real              A_in,
  output logic             busy,
  output logic [NBITS-1:0] trial,
  output logic [NBITS-1:0] D_out,
  output logic             valid
);

  localparam int  IDX_W      = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam real FULL_SCALE = real'(1 << NBITS);
  localparam logic [NBITS-1:0] MSB_CODE = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t           state_reg, state_next;
  real              held_reg, held_next;
  logic [NBITS-1:0] trial_reg, trial_next;
  logic [NBITS-1:0] d_out_reg, d_out_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;

  logic [NBITS-1:0] idx_onehot;
  logic [NBITS-1:0] lower_onehot;
  logic [NBITS-1:0] resolved_code;
  real              v_trial;

  // One-hot select of the bit currently under test.
  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_idx
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign lower_onehot = idx_onehot >> 1;
  assign v_trial      = real'(trial_reg) * Vref / FULL_SCALE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      held_reg  <= 0.0;
      trial_reg <= '0;
      d_out_reg <= '0;
      idx_reg   <= TOP_IDX;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      trial_reg <= trial_next;
      d_out_reg <= d_out_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    held_next     = held_reg;
    trial_next    = trial_reg;
    d_out_next    = d_out_reg;
    idx_next      = idx_reg;
    valid_next    = 1'b0;
    busy_next     = busy_reg;
    resolved_code = (held_reg >= v_trial) ? trial_reg : (trial_reg & ~idx_onehot);

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (en && start) begin
          state_next = SAMPLE;
          busy_next  = 1'b1;
        end
      end
      SAMPLE: begin
        if (!en) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          trial_next = '0;
        end else begin
          held_next  = A_in;
          trial_next = MSB_CODE;
          idx_next   = TOP_IDX;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (!en) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          trial_next = '0;
        end else if (idx_reg != '0) begin
          trial_next = resolved_code | lower_onehot;
          idx_next   = idx_reg - 1'b1;
        end else begin
          // Last bit resolved: publish the code and release the converter.
          d_out_next = resolved_code;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          trial_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        trial_next = '0;
      end
    endcase
  end

  assign busy  = busy_reg;
  assign trial = trial_reg;
  assign D_out = d_out_reg;
  assign valid = valid_reg;

endmodule

// File: doc/sar_adc.md
Name: sar_adc

Overview:
- Behavioural successive-approximation ADC: the analog-to-digital counterpart of the team's 8-bit DAC model.
- Samples a real-valued analog input on request and resolves one bit per clock, MSB first, against an internal trial DAC.
- Presents the final code with a one-cycle valid strobe.
- Sits in the sine-wave bench to digitise the DAC output for loop-back checking; it also serves as a stand-alone converter model.

Parameters:
- Vref, 3.3 (real): full-scale reference voltage in volts.
- NBITS, 8: resolution. Legal range is 2..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  converter enable. Low aborts any conversion in flight.
- start  input  1  conversion request, sampled in IDLE only.
- A_in  input  real  analog input voltage.
- busy  output  1  high while a conversion is in progress.
- trial  output  NBITS  current trial code driven to the internal DAC (debug/observation).
- D_out  output  NBITS  last completed conversion result.
- valid  output  1  one-cycle strobe; high when D_out has just been updated.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, valid=0, D_out=0, trial=0; held sample=0.0; bit index=NBITS-1.
- States: IDLE, SAMPLE, CONVERT.
- IDLE:
  - valid is cleared on every edge unless set by a conversion completing on that edge.
  - If en && start at edge E0, go to SAMPLE and set busy=1.
  - start with en=0 is ignored.
- SAMPLE (edge E1):
  - Latch A_in into the held sample.
  - Set trial = 1<<(NBITS-1) and index = NBITS-1.
  - Go to CONVERT.
- CONVERT, one edge per bit (E2..E(NBITS+1)):
  - V_trial = trial*Vref/2^NBITS, in real arithmetic.
  - If held >= V_trial, keep bit[index]; otherwise clear it.
  - If index > 0: set bit[index-1] in trial and decrement index.
  - If index == 0: load D_out with the resolved code, pulse valid=1, set busy=0, clear trial to 0, and return to IDLE.
- Latency: start sampled at E0 gives valid high during the cycle after edge E(NBITS+1). That is 10 edges for NBITS=8.
- Result: D_out = floor(held*2^NBITS/Vref), clamped to [0, 2^NBITS-1].
  - A_in <= 0.0 gives 0.
  - A_in >= Vref*(2^NBITS-1)/2^NBITS gives all ones.
  - Equality with a trial voltage keeps the bit.
- Single sample: A_in changes after E1 have no effect on the result.
- start while busy: ignored. No queueing, and no restart of the conversion in flight.
- Back-to-back conversions: the earliest next start is sampled at the edge after valid is set, so the minimum period is NBITS+2 edges.
- en low during SAMPLE or CONVERT:
  - Next edge returns to IDLE with busy=0 and trial=0.
  - valid is not pulsed and D_out retains its previous value.
- rst_n asserted mid-conversion: immediate return to reset values, including D_out=0.
- valid and busy are never high in the same cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, valid=0, D_out=0; after release with en=0, no conversion starts.
- Mid-scale: Vref=3.3, NBITS=8, A_in=1.70, one-cycle start -> trial sequence 128,192,160,144,136,132,130,131 on successive cycles; D_out=131 (0x83); valid high exactly one cycle, 10 edges after start.
- Limits: A_in=0.0 -> D_out=0; A_in=3.3 -> D_out=255; A_in=-0.5 -> D_out=0; A_in=1.65 (exact trial 128) -> D_out=128.
- Sample-and-hold plus ignored start: A_in=1.0 at E1, then A_in=3.0 and start pulsed during CONVERT -> D_out=77, busy never re-asserts early, a single valid pulse.
- Abort: deassert en at the 4th CONVERT edge with previous D_out=131 -> busy drops next edge, no valid, D_out stays 131; a fresh start then converts normally.
- Loop-back: the DAC model drives codes 0, 64, 200, 255 into A_in -> D_out returns each code exactly (±0 LSB), and back-to-back conversions run at one per 10 edges.
